// File: rtl/nes_io_pkg.sv
// Shared constants and types for the NES joypad port.
// Latency: n/a (package only).
// Backpressure: n/a.
package nes_io_pkg;

    localparam logic [23:0] JOY1_ADDR    = 24'h004016;
    localparam logic [23:0] JOY2_ADDR    = 24'h004017;
    localparam logic [7:0]  JOY_OPEN_BUS = 8'h40;

    // Bit position of each button in the pad byte, index 0 is shifted out first
    typedef enum logic [2:0] {
        BTN_A      = 3'd0,
        BTN_B      = 3'd1,
        BTN_SELECT = 3'd2,
        BTN_START  = 3'd3,
        BTN_UP     = 3'd4,
        BTN_DOWN   = 3'd5,
        BTN_LEFT   = 3'd6,
        BTN_RIGHT  = 3'd7
    } btn_idx_e;

    // Byte the databus returns for a joypad read: fixed open-bus bits plus serial data bit
    function automatic logic [7:0] joy_byte(input logic data_bit);
        return JOY_OPEN_BUS | {7'b000_0000, data_bit};
    endfunction

endpackage

// File: rtl/nes_controller_port_debounce.sv
// One button bit: 2-flop synchroniser followed by a stability-counter debouncer.
// Latency: 2 cycles sync + DEBOUNCE_CYCLES of stability before the output moves.
// Backpressure: none, free-running.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic deb
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    // Synchroniser next-state
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    // Synchroniser flops
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign deb = sync2_q;
    end else begin : g_deb
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic             deb_q, deb_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Count consecutive cycles of disagreement; adopt the new value on the last one
        always_comb begin
            deb_d = deb_q;
            cnt_d = '0;
            if (sync2_q != deb_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Debounce state flops
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                deb_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                deb_q <= deb_d;
                cnt_q <= cnt_d;
            end
        end

        assign deb = deb_q;
    end

endmodule

// File: rtl/nes_controller_port.sv
// CPU-side responder for the $4016/$4017 joypad registers with 4021-style serial readout.
// Latency: CONTROLx is combinational from the shift registers; shifts land after a read ends.
// Backpressure: none; every CPU access is accepted, multi-cycle accesses count once.
module nes_controller_port
    import nes_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [23:0] ADDR,
    input  logic        CPU_CE,
    input  logic        CPU_WE,
    input  logic [7:0]  CPU_DO,
    input  logic [7:0]  PAD1_BTN,
    input  logic [7:0]  PAD2_BTN,
    output logic [7:0]  CONTROL1,
    output logic [7:0]  CONTROL2,
    output logic        STROBE
);

    logic [15:0] raw_all;
    logic [15:0] deb_all;
    logic [7:0]  deb1, deb2;

    assign raw_all = {PAD2_BTN, PAD1_BTN};

    for (genvar i = 0; i < 16; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .Clk  (Clk),
            .Reset(Reset),
            .raw  (raw_all[i]),
            .deb  (deb_all[i])
        );
    end

    assign deb1 = deb_all[7:0];
    assign deb2 = deb_all[15:8];

    // Only bit 0 of a $4016 write is meaningful to the pads
    logic unused_cpu_do;
    assign unused_cpu_do = ^CPU_DO[7:1];

    logic rd1, rd2, wr1;
    logic rd1_q, rd1_d;
    logic rd2_q, rd2_d;
    logic wr1_q, wr1_d;
    logic strobe_q, strobe_d;
    logic [7:0] sr1_q, sr1_d;
    logic [7:0] sr2_q, sr2_d;

    assign rd1 = CPU_CE & ~CPU_WE & (ADDR == JOY1_ADDR);
    assign rd2 = CPU_CE & ~CPU_WE & (ADDR == JOY2_ADDR);
    assign wr1 = CPU_CE &  CPU_WE & (ADDR == JOY1_ADDR);

    // Access edge detection, strobe latch and shift-register next-state
    always_comb begin
        rd1_d    = rd1;
        rd2_d    = rd2;
        wr1_d    = wr1;
        strobe_d = strobe_q;
        sr1_d    = sr1_q;
        sr2_d    = sr2_q;

        if (wr1 && !wr1_q) begin
            strobe_d = CPU_DO[0];
        end

        // Reload takes priority, so a read edge in the cycle strobe drops does not shift
        if (strobe_q) begin
            sr1_d = deb1;
            sr2_d = deb2;
        end else begin
            if (rd1_q && !rd1) begin
                sr1_d = {1'b1, sr1_q[7:1]};
            end
            if (rd2_q && !rd2) begin
                sr2_d = {1'b1, sr2_q[7:1]};
            end
        end
    end

    // Port state flops; reset clears edge history so an access in flight restarts cleanly
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd1_q    <= 1'b0;
            rd2_q    <= 1'b0;
            wr1_q    <= 1'b0;
            strobe_q <= 1'b0;
            sr1_q    <= 8'h00;
            sr2_q    <= 8'h00;
        end else begin
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            wr1_q    <= wr1_d;
            strobe_q <= strobe_d;
            sr1_q    <= sr1_d;
            sr2_q    <= sr2_d;
        end
    end

    assign CONTROL1 = joy_byte(sr1_q[BTN_A]);
    assign CONTROL2 = joy_byte(sr2_q[BTN_A]);
    assign STROBE   = strobe_q;

endmodule

// File: doc/nes_controller_port.md
Name: nes_controller_port

Overview:
- CPU-facing responder for the two NES joypad registers at $4016/$4017.
- Latches the 8 button states of each pad on the strobe and serialises them one bit per CPU read, as the original 4021 shift-register pads do.
- Supplies the CONTROL1/CONTROL2 bytes that the databus returns on reads of $4016/$4017, and consumes CPU writes to $4016.
- Button sources are parallel, asynchronous inputs (keyboard/pad decoder); this block synchronises and debounces them.

Parameters:
- DEBOUNCE_CYCLES, 16, raw button must be stable this many Clk cycles before its debounced value changes; 0 = bypass (synchroniser only).
- CNT_W, 16, width of each debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- ADDR  in  24  CPU address.
- CPU_CE  in  1  CPU access valid; may stay high for several Clk cycles per access.
- CPU_WE  in  1  1 = write, 0 = read; qualified by CPU_CE.
- CPU_DO  in  8  CPU write data.
- PAD1_BTN  in  8  raw pad 1 buttons, 1 = pressed, async.
- PAD2_BTN  in  8  raw pad 2 buttons, 1 = pressed, async.
- CONTROL1  out  8  read value for $4016.
- CONTROL2  out  8  read value for $4017.
- STROBE  out  1  current strobe latch, for debug.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- Button bit order, index 0 first: A, B, Select, Start, Up, Down, Left, Right.
- Input conditioning:
  - Each raw bit passes through a 2-flop synchroniser, then a debouncer.
  - The debounced bit takes the synchronised value once it has differed from the debounced value for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the debounced value clears the counter.
- Access events:
  - rd_n = CPU_CE & ~CPU_WE & ADDR==n.
  - wr_n = CPU_CE & CPU_WE & ADDR==n.
  - A registered copy of each rd/wr qualifier gives edge detection.
  - A multi-cycle access counts as exactly one event.
- Strobe:
  - On the first cycle of wr_4016, strobe <= CPU_DO[0].
  - Writes to $4017 are ignored; that address is the APU frame counter, not this block.
- Shift registers SR1, SR2, 8 bits each:
  - While strobe = 1: SR1 <= deb1 and SR2 <= deb2 every cycle. Reads return the live A bit and do not shift.
  - When strobe = 0: SR holds. On the falling edge of rd_4016, SR1 <= {1'b1, SR1[7:1]}; rd_4017 does the same for SR2.
  - Shift happens at the end of the access, so the value read is stable for the whole access.
  - After 8 reads, every further read returns 1, because 1s are shifted in.
- Outputs:
  - Combinational from registers: CONTROL1 = {3'b010, 4'b0000, SR1[0]}, so it is $40 or $41 (open-bus upper bits fixed at $40). CONTROL2 is formed the same way from SR2.
  - No added latency: CONTROL reflects the SR state of the current cycle.
- Simultaneous events:
  - Strobe going 1->0 in the same cycle as a read edge: the reload of that cycle wins and no shift occurs.
  - A write to $4016 never shifts SR1.
  - Reads of both pads within one window shift independently.
- Reset values:
  - strobe = 0; SR1 = SR2 = 8'h00.
  - CONTROL1 = CONTROL2 = 8'h40; STROBE = 0.
  - Synchronisers, debounced values and counters = 0; edge-detect flops = 0.
- Reset mid-access:
  - Any pending edge is discarded.
  - After reset deassertion with CPU_CE still high, the ongoing access is treated as a new access: its start edge is detected, and it shifts on its end edge.

Decomposition:
- Package nes_io_pkg holds:
  - Address constants JOY1_ADDR = 24'h4016 and JOY2_ADDR = 24'h4017.
  - The button index enum (BTN_A .. BTN_RIGHT).
  - The open-bus constant JOY_OPEN_BUS = 8'h40.
- Sub-module button_debounce: 1-bit synchroniser plus counter, parameterised by DEBOUNCE_CYCLES. Instantiate it 16 times with generate.

Test Plan:
- After reset, with no strobe: read $4016 → $40; after 8 reads, the 9th read → $41.
- PAD1_BTN = 8'b1000_0101 held > DEBOUNCE_CYCLES, write $01 then $00 to $4016 → 8 reads give $41,$40,$41,$40,$40,$40,$40,$41, then $41 forever.
- Strobe held at 1, pulse A on/off → every $4016 read tracks the debounced A; SR1 never shifts.
- A 5-cycle read access to $4017 → exactly one shift of SR2; SR1 unchanged; CONTROL2 stable across the access.
- Raw A glitch shorter than DEBOUNCE_CYCLES, then strobe → A reads $40; write $xx to $4017 → no state change.
- Assert Reset between a read's first and last cycle → outputs $40, strobe 0; access end after deassertion shifts once only.
